key_filter3: RTL and testbench

Three-channel push-button conditioner that sits directly upstream of the `block_nonblock` combiner and drives its `a`, `b` and `c` inputs. Each raw, active-low, asynchronous key input passes through a two-flop synchronizer and an independent debounce state machine. The block produces a clean, active-high pressed level plus one-cycle press and release pulses per channel. It replaces the hand-driven a/b/c stimulus with real board keys.

---
 rtl/key_filter3.sv | 138 +++++++++++++
 tb/tb_key_filter3.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/key_filter3.sv
// -----------------------------------------------------------------------------
// key_filter3
//   Three-channel push-button conditioner. Each raw active-low key is passed
//   through a synchronizer and an independent debounce FSM, producing a clean
//   active-high level plus one-cycle press / release pulses per channel.
//   Bit 0 feeds combiner input a, bit 1 feeds b, bit 2 feeds c.
//
// Parameters
//   CNT_MAX      debounce window in Clk cycles (>= 2)
//
// Ports
//   Clk          system clock, all state on the rising edge
//   Rst          asynchronous reset, active low
//   key_in       raw keys, active low (0 = pressed), asynchronous to Clk
//   key_level    debounced level, 1 = pressed (registered)
//   key_press    one-cycle pulse when a press is confirmed (registered)
//   key_release  one-cycle pulse when a release is confirmed (registered)
// -----------------------------------------------------------------------------
module key_filter3 #(
    parameter int CNT_MAX = 1_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] key_in,
    output logic [2:0] key_level,
    output logic [2:0] key_press,
    output logic [2:0] key_release
);

    localparam int              CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,     // released, stable
        FILT_DN,  // candidate press, counting the stable-low window
        DOWN,     // pressed, stable
        FILT_UP   // candidate release, counting the stable-high window
    } state_t;

    for (genvar i = 0; i < 3; i++) begin : g_ch

        logic            r_s1, r_s2, r_s3;
        logic            w_fall, w_rise;
        state_t          r_state, w_state_nx;
        logic [CW-1:0]   r_cnt, w_cnt_nx;
        logic            r_level, r_press, r_release;
        logic            w_level_nx, w_press_nx, w_release_nx;

        // Synchronizer plus one extra stage for edge detection. Reset value 1
        // means "released", so a key held through reset shows up as a fall.
        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                r_s1 <= 1'b1;
                r_s2 <= 1'b1;
                r_s3 <= 1'b1;
            end else begin
                // NOTE: non-blocking assignments make this a true shift
                // register; blocking ones would collapse the three stages.
                r_s1 <= key_in[i];
                r_s2 <= r_s1;
                r_s3 <= r_s2;
            end
        end

        assign w_fall = r_s3 & ~r_s2;
        assign w_rise = ~r_s3 & r_s2;

        always_comb begin
            // NOTE: every output of this block gets a default first, so no
            // path through the case statement can infer a latch.
            w_state_nx   = r_state;
            w_cnt_nx     = '0;
            w_press_nx   = 1'b0;
            w_release_nx = 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (w_fall) w_state_nx = FILT_DN;
                end
                FILT_DN: begin
                    if (r_cnt == CNT_LAST) begin
                        // The press is confirmed. A rise arriving on the same
                        // edge must not be lost, so go straight to the
                        // release filter instead of DOWN.
                        w_press_nx = 1'b1;
                        w_state_nx = w_rise ? FILT_UP : DOWN;
                    end else if (w_rise) begin
                        w_state_nx = IDLE;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                DOWN: begin
                    if (w_rise) w_state_nx = FILT_UP;
                end
                FILT_UP: begin
                    if (r_cnt == CNT_LAST) begin
                        // Mirror of FILT_DN: a coincident fall restarts the
                        // press filter.
                        w_release_nx = 1'b1;
                        w_state_nx   = w_fall ? FILT_DN : IDLE;
                    end else if (w_fall) begin
                        w_state_nx = DOWN;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                default: w_state_nx = IDLE;
            endcase

            // The debounced level is "pressed" in DOWN and while a release is
            // still only a candidate.
            w_level_nx = (w_state_nx == DOWN) || (w_state_nx == FILT_UP);
        end

        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_nx;
                r_cnt     <= w_cnt_nx;
                r_level   <= w_level_nx;
                r_press   <= w_press_nx;
                r_release <= w_release_nx;
            end
        end

        assign key_level[i]   = r_level;
        assign key_press[i]   = r_press;
        assign key_release[i] = r_release;

    end : g_ch

endmodule

// File: tb/tb_key_filter3.sv
// -----------------------------------------------------------------------------
// tb_key_filter3
//   Directed and randomized stimulus for key_filter3 (CNT_MAX = 10). The
//   reference model keeps a history of the raw samples taken at each clock
//   edge and derives the debounced outputs from run lengths: a channel's level
//   flips on the edge where a run of opposite-polarity samples, seen three
//   edges late through the synchronizer, reaches exactly CNT_MAX.
// -----------------------------------------------------------------------------
module tb_key_filter3;

    localparam int CNT_MAX = 10;
    localparam int HIST    = CNT_MAX + 8;

    logic       Clk;
    logic       Rst;
    logic [2:0] key_in;
    logic [2:0] key_level;
    logic [2:0] key_press;
    logic [2:0] key_release;

    key_filter3 #(.CNT_MAX(CNT_MAX)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [2:0] hist[$];
    logic [2:0] m_level;
    logic [2:0] m_press;
    logic [2:0] m_release;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Before any sample is taken every key is considered released.
    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < CNT_MAX + 5; j++) hist.push_back(3'b111);
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
    endtask

    task automatic model_step(input logic [2:0] k);
        int   idx;
        int   run;
        logic v;
        hist.push_back(k);
        if (hist.size() > HIST) void'(hist.pop_front());
        m_press   = '0;
        m_release = '0;
        idx = hist.size() - 4;
        for (int ch = 0; ch < 3; ch++) begin
            v   = hist[idx][ch];
            run = 0;
            for (int j = idx; j >= 0; j--) begin
                if (hist[j][ch] != v) break;
                run++;
            end
            if (run == CNT_MAX) begin
                if (!v && !m_level[ch]) begin
                    m_level[ch] = 1'b1;
                    m_press[ch] = 1'b1;
                end else if (v && m_level[ch]) begin
                    m_level[ch]   = 1'b0;
                    m_release[ch] = 1'b1;
                end
            end
        end
    endtask

    // Drive k shortly after an edge, let the next edge sample it, then compare
    // all outputs with the model 1 ns after that edge.
    task automatic tick(input logic [2:0] k, input string tag);
        key_in = k;
        @(posedge Clk);
        model_step(k);
        #1;
        check({tag, ".level"},   key_level,   m_level);
        check({tag, ".press"},   key_press,   m_press);
        check({tag, ".release"}, key_release, m_release);
    endtask

    // Hold a pattern for 15 edges; t = 0 is the first edge that samples it.
    // The directed expectation is the pulse pattern on edge 12 and the level
    // one edge earlier.
    task automatic hold15(input logic [2:0] k, input string tag,
                          input logic [2:0] exp_press, input logic [2:0] exp_release,
                          input logic [2:0] exp_level_e11);
        for (int t = 0; t < 15; t++) begin
            tick(k, tag);
            if (t == 11) check({tag, "@E11.level"}, key_level, exp_level_e11);
            if (t == 12) begin
                check({tag, "@E12.press"},   key_press,   exp_press);
                check({tag, "@E12.release"}, key_release, exp_release);
            end
        end
    endtask

    initial begin
        logic [2:0] cur;
        logic [2:0] flip;

        // Reset with random keys: outputs must stay quiet.
        Rst    = 1'b0;
        key_in = 3'($urandom);
        model_reset();
        repeat (10) begin
            @(posedge Clk);
            key_in = 3'($urandom);
            #1;
            check("reset.level",   key_level,   3'b000);
            check("reset.press",   key_press,   3'b000);
            check("reset.release", key_release, 3'b000);
        end
        Rst = 1'b1;
        repeat (3) tick(3'b111, "post_reset");

        // Clean press and release on channel 0.
        hold15(3'b110, "press0",   3'b001, 3'b000, 3'b000);
        hold15(3'b111, "release0", 3'b000, 3'b001, 3'b001);

        // Bounce on channel 1: no event, then a genuine press.
        repeat (4) tick(3'b101, "bounce1");
        repeat (2) tick(3'b111, "bounce1");
        repeat (6) tick(3'b101, "bounce1");
        repeat (3) tick(3'b111, "bounce1");
        check("bounce1.no_level", key_level, 3'b000);
        hold15(3'b101, "press1",   3'b010, 3'b000, 3'b000);
        hold15(3'b111, "release1", 3'b000, 3'b010, 3'b010);

        // Channel 2 press then release.
        hold15(3'b011, "press2",   3'b100, 3'b000, 3'b000);
        hold15(3'b111, "release2", 3'b000, 3'b100, 3'b100);

        // All keys on the same edge.
        hold15(3'b000, "press_all",   3'b111, 3'b000, 3'b000);
        check("press_all.level", key_level, 3'b111);
        hold15(3'b111, "release_all", 3'b000, 3'b111, 3'b111);

        // Reset while channel 0 is mid-filter (counter at 5 after edge 7).
        repeat (8) tick(3'b110, "midfilt");
        Rst = 1'b0;
        #1;
        check("midreset.level",   key_level,   3'b000);
        check("midreset.press",   key_press,   3'b000);
        check("midreset.release", key_release, 3'b000);
        model_reset();
        repeat (3) begin
            @(posedge Clk);
            #1;
            check("midreset.hold", key_level, 3'b000);
        end
        Rst = 1'b1;
        hold15(3'b110, "held_thru_reset", 3'b001, 3'b000, 3'b000);
        hold15(3'b111, "release_after",   3'b000, 3'b001, 3'b001);

        // Random bouncy keys: each bit flips with probability 1/8 per cycle,
        // so runs straddle the debounce window in both directions.
        cur = 3'b111;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 3; b++) flip[b] = ($urandom_range(7) == 0);
            cur = cur ^ flip;
            tick(cur, "random");
        end
        repeat (CNT_MAX + 5) tick(3'b111, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
